// File: rtl/instruction_decode_if.sv
// Fetch / write-back / ID-EX signal bundle for the MIPS32 decode stage.
// The slave modport is the decode stage; the master drives it from upstream.
interface instruction_decode_if;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [9:0]  if_pc;
  logic        ex_stall;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        load_use_stall;
  logic        id_valid;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_dest;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [2:0]  id_alu_op;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_mem_to_reg;
  logic        id_alu_src;
  logic        id_branch;
  logic        id_jump;
  logic        id_illegal;
  logic [9:0]  id_pc_plus1;
  logic [9:0]  id_branch_target;
  logic [9:0]  id_jump_target;

  modport slave (
    input  if_valid, if_instr, if_pc, ex_stall, flush, wb_en, wb_addr, wb_data,
    output load_use_stall, id_valid, id_rs_data, id_rt_data, id_imm, id_dest,
           id_rs, id_rt, id_alu_op, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, id_alu_src, id_branch, id_jump, id_illegal,
           id_pc_plus1, id_branch_target, id_jump_target
  );

  modport master (
    output if_valid, if_instr, if_pc, ex_stall, flush, wb_en, wb_addr, wb_data,
    input  load_use_stall, id_valid, id_rs_data, id_rt_data, id_imm, id_dest,
           id_rs, id_rt, id_alu_op, id_reg_write, id_mem_read, id_mem_write,
           id_mem_to_reg, id_alu_src, id_branch, id_jump, id_illegal,
           id_pc_plus1, id_branch_target, id_jump_target
  );
endinterface

// File: rtl/instruction_decode.sv
// MIPS32 instruction decode stage: register file with write-through bypass,
// control decode, branch/jump targets, load-use detection and the ID/EX register.
module instruction_decode (
  input  logic                  clk,
  input  logic                  rst_n,
  instruction_decode_if.slave   bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23,
                         OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_J = 6'h02;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
                         ALU_OR = 3'd3, ALU_SLT = 3'd4;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic branch;
    logic jump;
    logic illegal;
  } ctrl_t;

  typedef struct packed {
    logic        valid;
    ctrl_t       ctrl;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [2:0]  alu_op;
    logic [9:0]  pc_plus1;
    logic [9:0]  branch_target;
    logic [9:0]  jump_target;
  } idex_t;

  logic [31:0] rf_q [32];
  idex_t       idex_q, idex_d;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rs_val, rt_val;
  ctrl_t       dec_ctrl;
  logic [2:0]  dec_alu_op;
  logic [4:0]  dec_dest;
  logic        reads_rt;
  logic        load_use;

  assign opcode = bus.if_instr[31:26];
  assign rs     = bus.if_instr[25:21];
  assign rt     = bus.if_instr[20:16];
  assign rd     = bus.if_instr[15:11];
  assign funct  = bus.if_instr[5:0];

  // r0 is never written, so its storage stays at the reset value of 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (bus.wb_en && bus.wb_addr != 5'd0) begin
      rf_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_comb begin
    rs_val = rf_q[rs];
    rt_val = rf_q[rt];
    if (bus.wb_en && bus.wb_addr != 5'd0 && bus.wb_addr == rs) rs_val = bus.wb_data;
    if (bus.wb_en && bus.wb_addr != 5'd0 && bus.wb_addr == rt) rt_val = bus.wb_data;
    if (rs == 5'd0) rs_val = '0;
    if (rt == 5'd0) rt_val = '0;
  end

  always_comb begin
    dec_ctrl   = '0;
    dec_alu_op = ALU_ADD;
    dec_dest   = 5'd0;
    reads_rt   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reads_rt = 1'b1;
        case (funct)
          6'h20: dec_alu_op = ALU_ADD;
          6'h22: dec_alu_op = ALU_SUB;
          6'h24: dec_alu_op = ALU_AND;
          6'h25: dec_alu_op = ALU_OR;
          6'h2A: dec_alu_op = ALU_SLT;
          default: dec_ctrl.illegal = 1'b1;
        endcase
        if (!dec_ctrl.illegal) begin
          dec_ctrl.reg_write = 1'b1;
          dec_dest           = rd;
        end
      end
      OP_ADDI: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_dest           = rt;
      end
      OP_LW: begin
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
        dec_dest            = rt;
      end
      OP_SW: begin
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        reads_rt           = 1'b1;
      end
      OP_BEQ: begin
        dec_ctrl.branch = 1'b1;
        dec_alu_op      = ALU_SUB;
        reads_rt        = 1'b1;
      end
      OP_J:    dec_ctrl.jump = 1'b1;
      default: dec_ctrl.illegal = 1'b1;
    endcase
  end

  assign load_use = idex_q.valid && idex_q.ctrl.mem_read && idex_q.dest != 5'd0 &&
                    bus.if_valid &&
                    (idex_q.dest == rs || (reads_rt && idex_q.dest == rt));

  // A killed or bubbled entry also clears its controls so nothing downstream acts on it.
  always_comb begin
    idex_d = idex_q;
    if (bus.flush || (!bus.ex_stall && load_use)) begin
      idex_d.valid = 1'b0;
      idex_d.ctrl  = '0;
    end else if (!bus.ex_stall) begin
      idex_d.valid         = bus.if_valid;
      idex_d.ctrl          = bus.if_valid ? dec_ctrl : '0;
      idex_d.rs_data       = rs_val;
      idex_d.rt_data       = rt_val;
      idex_d.imm           = {{16{bus.if_instr[15]}}, bus.if_instr[15:0]};
      idex_d.dest          = dec_dest;
      idex_d.rs            = rs;
      idex_d.rt            = rt;
      idex_d.alu_op        = dec_alu_op;
      idex_d.pc_plus1      = bus.if_pc + 10'd1;
      idex_d.branch_target = bus.if_pc + 10'd1 + bus.if_instr[9:0];
      idex_d.jump_target   = bus.if_instr[9:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign bus.load_use_stall   = load_use;
  assign bus.id_valid         = idex_q.valid;
  assign bus.id_rs_data       = idex_q.rs_data;
  assign bus.id_rt_data       = idex_q.rt_data;
  assign bus.id_imm           = idex_q.imm;
  assign bus.id_dest          = idex_q.dest;
  assign bus.id_rs            = idex_q.rs;
  assign bus.id_rt            = idex_q.rt;
  assign bus.id_alu_op        = idex_q.alu_op;
  assign bus.id_reg_write     = idex_q.ctrl.reg_write;
  assign bus.id_mem_read      = idex_q.ctrl.mem_read;
  assign bus.id_mem_write     = idex_q.ctrl.mem_write;
  assign bus.id_mem_to_reg    = idex_q.ctrl.mem_to_reg;
  assign bus.id_alu_src       = idex_q.ctrl.alu_src;
  assign bus.id_branch        = idex_q.ctrl.branch;
  assign bus.id_jump          = idex_q.ctrl.jump;
  assign bus.id_illegal       = idex_q.ctrl.illegal;
  assign bus.id_pc_plus1      = idex_q.pc_plus1;
  assign bus.id_branch_target = idex_q.branch_target;
  assign bus.id_jump_target   = idex_q.jump_target;
endmodule

// File: tb/tb_instruction_decode.sv
// Directed-vector bench for instruction_decode; expected values are hand-computed
// from the instruction encodings.
module tb_instruction_decode;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  instruction_decode_if bus ();

  instruction_decode dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] instr, input logic [9:0] pc);
    bus.if_valid = 1'b1;
    bus.if_instr = instr;
    bus.if_pc    = pc;
    $display("fetch pc=0x%03h instr=0x%08h stall_in=%0b flush=%0b", pc, instr,
             bus.ex_stall, bus.flush);
  endtask

  logic [31:0] funct_instr [5] = '{32'h00221822, 32'h00221824, 32'h00221825,
                                   32'h0022182A, 32'h00221821};
  logic [2:0]  funct_op    [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
  logic        funct_ill   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0;
    bus.ex_stall = 1'b0; bus.flush = 1'b0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    #12;
    check("rst_valid", bus.id_valid, 0);
    check("rst_lus", bus.load_use_stall, 0);
    check("rst_rsdata", bus.id_rs_data, 0);
    check("rst_regw", bus.id_reg_write, 0);
    rst_n = 1'b1;

    // Write r1=5, r2=7, then ADD r3,r1,r2
    bus.wb_en = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'd5;
    step();
    bus.wb_addr = 5'd2; bus.wb_data = 32'd7;
    step();
    bus.wb_en = 1'b0;
    fetch(32'h00221820, 10'h010);
    step();
    check("add_rs_data", bus.id_rs_data, 5);
    check("add_rt_data", bus.id_rt_data, 7);
    check("add_dest", bus.id_dest, 3);
    check("add_aluop", bus.id_alu_op, 0);
    check("add_regw", bus.id_reg_write, 1);
    check("add_valid", bus.id_valid, 1);
    check("add_rs", bus.id_rs, 1);
    check("add_rt", bus.id_rt, 2);
    check("add_pc1", bus.id_pc_plus1, 10'h011);

    // Bypass: write r4 while ADD r5,r4,r0 reads it
    bus.wb_en = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'hDEADBEEF;
    fetch(32'h00802820, 10'h011);
    step();
    check("bypass_rs", bus.id_rs_data, 32'hDEADBEEF);
    check("bypass_rt_r0", bus.id_rt_data, 0);
    bus.wb_addr = 5'd0; bus.wb_data = 32'h12345678;
    fetch(32'h00003020, 10'h012);
    step();
    check("r0_bypass", bus.id_rs_data, 0);
    check("r0_dest", bus.id_dest, 6);
    bus.wb_en = 1'b0;
    step();
    check("r0_after_write", bus.id_rs_data, 0);
    fetch(32'h00843820, 10'h013);
    step();
    check("r4_stored_rs", bus.id_rs_data, 32'hDEADBEEF);
    check("r4_stored_rt", bus.id_rt_data, 32'hDEADBEEF);

    // R-type funct table
    for (int i = 0; i < 5; i++) begin
      fetch(funct_instr[i], 10'h014);
      step();
      check($sformatf("funct%0d_aluop", i), bus.id_alu_op, funct_op[i]);
      check($sformatf("funct%0d_illegal", i), bus.id_illegal, funct_ill[i]);
      check($sformatf("funct%0d_regw", i), bus.id_reg_write, !funct_ill[i]);
      check($sformatf("funct%0d_dest", i), bus.id_dest, funct_ill[i] ? 0 : 3);
    end

    // Load-use: LW r2,0(r1) then ADD r3,r2,r1
    fetch(32'h8C220000, 10'h030);
    step();
    check("lw_memrd", bus.id_mem_read, 1);
    check("lw_m2r", bus.id_mem_to_reg, 1);
    check("lw_alusrc", bus.id_alu_src, 1);
    check("lw_dest", bus.id_dest, 2);
    check("lw_rs_data", bus.id_rs_data, 5);
    fetch(32'h00411820, 10'h031);
    #1;
    check("lu_stall", bus.load_use_stall, 1);
    step();
    check("lu_bubble_valid", bus.id_valid, 0);
    check("lu_bubble_memrd", bus.id_mem_read, 0);
    check("lu_bubble_regw", bus.id_reg_write, 0);
    check("lu_stall_clear", bus.load_use_stall, 0);
    step();
    check("lu_add_valid", bus.id_valid, 1);
    check("lu_add_dest", bus.id_dest, 3);
    check("lu_add_rs_data", bus.id_rs_data, 7);
    check("lu_add_rt_data", bus.id_rt_data, 5);
    check("lu_add_pc1", bus.id_pc_plus1, 10'h032);

    // LW r8,-4(r1) then ADDI r8,r3,1 (rt not read: no stall)
    fetch(32'h8C28FFFC, 10'h040);
    step();
    check("lw_imm_sext", bus.id_imm, 32'hFFFFFFFC);
    check("lw8_dest", bus.id_dest, 8);
    fetch(32'h20680001, 10'h041);
    #1;
    check("addi_nostall", bus.load_use_stall, 0);
    step();
    check("addi_valid", bus.id_valid, 1);
    check("addi_dest", bus.id_dest, 8);
    check("addi_alusrc", bus.id_alu_src, 1);
    check("addi_imm", bus.id_imm, 1);
    check("addi_regw", bus.id_reg_write, 1);
    check("addi_memrd", bus.id_mem_read, 0);

    // BEQ wrap, J, SW
    fetch(32'h10220003, 10'h3FE);
    step();
    check("beq_branch", bus.id_branch, 1);
    check("beq_aluop", bus.id_alu_op, 1);
    check("beq_target", bus.id_branch_target, 10'h002);
    check("beq_pc1", bus.id_pc_plus1, 10'h3FF);
    check("beq_dest", bus.id_dest, 0);
    check("beq_regw", bus.id_reg_write, 0);
    fetch(32'h08000155, 10'h100);
    step();
    check("j_jump", bus.id_jump, 1);
    check("j_target", bus.id_jump_target, 10'h155);
    check("j_regw", bus.id_reg_write, 0);
    check("j_branch", bus.id_branch, 0);
    fetch(32'hAC220008, 10'h101);
    step();
    check("sw_memwr", bus.id_mem_write, 1);
    check("sw_alusrc", bus.id_alu_src, 1);
    check("sw_dest", bus.id_dest, 0);
    check("sw_imm", bus.id_imm, 8);
    check("sw_rt_data", bus.id_rt_data, 7);

    // ex_stall hold for 3 cycles, then flush beats stall
    fetch(32'h00221820, 10'h020);
    step();
    bus.ex_stall = 1'b1;
    fetch(32'hAC220008, 10'h040);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold%0d_valid", i), bus.id_valid, 1);
      check($sformatf("hold%0d_dest", i), bus.id_dest, 3);
      check($sformatf("hold%0d_regw", i), bus.id_reg_write, 1);
      check($sformatf("hold%0d_memwr", i), bus.id_mem_write, 0);
      check($sformatf("hold%0d_pc1", i), bus.id_pc_plus1, 10'h021);
    end
    bus.flush = 1'b1;
    step();
    check("flush_stall_valid", bus.id_valid, 0);
    check("flush_stall_regw", bus.id_reg_write, 0);
    bus.ex_stall = 1'b0;
    fetch(32'h00221820, 10'h050);
    step();
    check("flush_valid", bus.id_valid, 0);
    bus.flush = 1'b0;
    bus.if_valid = 1'b0;
    step();
    check("ifinv_valid", bus.id_valid, 0);
    check("ifinv_regw", bus.id_reg_write, 0);

    // ex_stall together with load-use: hold, no bubble
    fetch(32'h8C220000, 10'h060);
    step();
    bus.ex_stall = 1'b1;
    fetch(32'h00411820, 10'h061);
    #1;
    check("stall_lu_comb", bus.load_use_stall, 1);
    step();
    check("stall_lu_valid", bus.id_valid, 1);
    check("stall_lu_memrd", bus.id_mem_read, 1);
    bus.ex_stall = 1'b0;
    step();
    check("stall_lu_bubble", bus.id_valid, 0);
    step();
    check("stall_lu_add", bus.id_valid, 1);
    check("stall_lu_add_dest", bus.id_dest, 3);

    // Illegal opcode
    fetch(32'hFC000000, 10'h070);
    step();
    check("ill_illegal", bus.id_illegal, 1);
    check("ill_valid", bus.id_valid, 1);
    check("ill_ctrl", {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write,
                       bus.id_mem_to_reg, bus.id_alu_src, bus.id_branch, bus.id_jump}, 0);
    check("ill_dest", bus.id_dest, 0);

    // Asynchronous reset between edges
    fetch(32'h00221820, 10'h020);
    step();
    check("pre_rst_valid", bus.id_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", bus.id_valid, 0);
    check("arst_regw", bus.id_reg_write, 0);
    check("arst_rsdata", bus.id_rs_data, 0);
    check("arst_pc1", bus.id_pc_plus1, 0);
    #1 rst_n = 1'b1;
    step();
    check("post_rst_valid", bus.id_valid, 1);
    check("post_rst_r1", bus.id_rs_data, 0);
    check("post_rst_r2", bus.id_rt_data, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
